// File: rtl/riscade_core_p_if.sv
// rtl/riscade_core_p_if.sv - memory bus between the riscade core and its memory
// Strobes and ack are active low; the core is the master.
interface riscade_core_p_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_re_;
  logic              mem_we_;
  logic              mem_ack_;

  modport master (
    output mem_addr, mem_wdata, mem_re_, mem_we_,
    input  mem_rdata, mem_ack_
  );

  modport slave (
    input  mem_addr, mem_wdata, mem_re_, mem_we_,
    output mem_rdata, mem_ack_
  );
endinterface

// File: rtl/riscade_core_p.sv
// rtl/riscade_core_p.sv - parametrised single-issue riscade core
// One FSM sequences fetch, execute and memory access over a req/ack bus.
module riscade_core_p #(
  parameter int               DATA_W   = 8,
  parameter int               ADDR_W   = 8,
  parameter int               NGPR     = 6,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_,
  riscade_core_p_if.master  mem,
  output logic              halted_,
  output logic [ADDR_W-1:0] dbg_pc
);

  typedef enum logic [2:0] {
    S_BOOT,
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        inst_q, inst_d;
  logic [DATA_W-1:0] fl_q, fl_d;
  logic [DATA_W-1:0] gpr_q [NGPR];
  logic [DATA_W-1:0] gpr_d [NGPR];

  logic [DATA_W-1:0] rd_val;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W-1:0] diff_w;
  logic              borrow_w;

  // Source operand for cpf: GPRs, flags, zero-extended pc; unmapped ids read zero.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NGPR; i++) begin
      if (inst_q[3:0] == 4'(i)) rd_val = gpr_q[i];
    end
    if (inst_q[3:0] == 4'd14) rd_val = fl_q;
    if (inst_q[3:0] == 4'd15) rd_val[ADDR_W-1:0] = pc_q;
  end

  assign sum_w    = {1'b0, gpr_q[0]} + {1'b0, gpr_q[1]};
  assign diff_w   = gpr_q[0] - gpr_q[1];
  assign borrow_w = gpr_q[0] < gpr_q[1];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    fl_d          = fl_q;
    gpr_d         = gpr_q;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    mem.mem_re_   = 1'b1;
    mem.mem_we_   = 1'b1;

    case (state_q)
      S_BOOT: state_d = S_FETCH;

      S_FETCH: begin
        mem.mem_re_  = 1'b0;
        mem.mem_addr = pc_q;
        if (!mem.mem_ack_) begin
          inst_d  = mem.mem_rdata[7:0];
          pc_d    = pc_q + ADDR_W'(1);
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        casez (inst_q)
          8'b0000_0000: ;
          8'b0001_????: gpr_d[0] = rd_val;
          8'b0010_????: begin
            for (int i = 0; i < NGPR; i++) begin
              if (inst_q[3:0] == 4'(i)) gpr_d[i] = gpr_q[0];
            end
            if (inst_q[3:0] == 4'd14) fl_d = gpr_q[0];
            // Conditional branch: overrides the increment already applied at fetch.
            if (inst_q[3:0] == 4'd15 && fl_q[0]) pc_d = gpr_q[0][ADDR_W-1:0];
          end
          8'h30, 8'h31: state_d = S_MEM;
          8'h32: gpr_d[0] = '0;
          8'h33: fl_d[0] = ~fl_q[0];
          8'h34: begin
            gpr_d[0] = sum_w[DATA_W-1:0];
            fl_d[1]  = sum_w[DATA_W];
          end
          8'h35: begin
            gpr_d[0] = diff_w;
            fl_d[1]  = borrow_w;
          end
          8'h3f: state_d = S_HALT;
          8'b01??_????: begin
            if (inst_q[4]) begin
              gpr_d[0][7:4] = inst_q[3:0];
            end else begin
              gpr_d[0]      = '0;
              gpr_d[0][3:0] = inst_q[3:0];
            end
          end
          8'b10??_0000: begin
            case (inst_q[5:4])
              2'b00:   fl_d[0] = (gpr_q[0] == '0);
              2'b01:   fl_d[0] = (gpr_q[0] != '0);
              2'b10:   fl_d[0] = gpr_q[0][DATA_W-1];
              default: fl_d[0] = gpr_q[0][0];
            endcase
          end
          default: fl_d[2] = 1'b1;
        endcase
      end

      S_MEM: begin
        mem.mem_addr = gpr_q[1][ADDR_W-1:0];
        if (inst_q[0]) begin
          mem.mem_we_   = 1'b0;
          mem.mem_wdata = gpr_q[0];
        end else begin
          mem.mem_re_ = 1'b0;
        end
        if (!mem.mem_ack_) begin
          if (!inst_q[0]) gpr_d[0] = mem.mem_rdata;
          state_d = S_FETCH;
        end
      end

      S_HALT: ;

      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      fl_q    <= '0;
      for (int i = 0; i < NGPR; i++) gpr_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      fl_q    <= fl_d;
      gpr_q   <= gpr_d;
    end
  end

  assign halted_ = (state_q != S_HALT);
  assign dbg_pc  = pc_q;

endmodule

// File: tb/tb_riscade_core_p.sv
// tb/tb_riscade_core_p.sv - self-checking bench for riscade_core_p
module tb_riscade_core_p;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_ = 1'b0;

  riscade_core_p_if #(.DATA_W(8),  .ADDR_W(8)) bus8();
  riscade_core_p_if #(.DATA_W(16), .ADDR_W(8)) bus16();
  logic       halted8_, halted16_;
  logic [7:0] pc8, pc16;

  riscade_core_p #(.DATA_W(8), .ADDR_W(8), .NGPR(6), .RESET_PC(8'h00)) dut8 (
    .clk(clk), .rst_(rst_), .mem(bus8), .halted_(halted8_), .dbg_pc(pc8));
  riscade_core_p #(.DATA_W(16), .ADDR_W(8), .NGPR(6), .RESET_PC(8'h10)) dut16 (
    .clk(clk), .rst_(rst_), .mem(bus16), .halted_(halted16_), .dbg_pc(pc16));

  int tests = 0;
  int fails = 0;

  logic [7:0] mem8 [256];
  logic [7:0] mem16 [256];
  int  wait_n = 0;
  bit  withhold = 1'b0;
  bit  clr_mon = 1'b0;
  logic [7:0] exp_wdata = 8'h00;
  int  acc_cnt = 0;
  int  st_count = 0, we_low = 0, re_low = 0, wd_bad = 0, hstr8 = 0, hstr16 = 0;
  logic [7:0] st_addr = 8'h00, st_data = 8'h00;
  logic strobe8, strobe16;

  assign strobe8  = !bus8.mem_re_ || !bus8.mem_we_;
  assign strobe16 = !bus16.mem_re_ || !bus16.mem_we_;

  always_comb begin
    bus8.mem_rdata  = mem8[bus8.mem_addr];
    bus8.mem_ack_   = !(strobe8 && !withhold && acc_cnt >= wait_n);
    bus16.mem_rdata = {8'h00, mem16[bus16.mem_addr]};
    bus16.mem_ack_  = !strobe16;
  end

  always @(posedge clk) begin
    if (strobe8 && bus8.mem_ack_) acc_cnt <= acc_cnt + 1;
    else                          acc_cnt <= 0;
    if (clr_mon) begin
      st_count <= 0;
    end else if (!bus8.mem_we_ && !bus8.mem_ack_) begin
      st_count <= st_count + 1;
      st_addr  <= bus8.mem_addr;
      st_data  <= bus8.mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (clr_mon) begin
      we_low <= 0; re_low <= 0; wd_bad <= 0; hstr8 <= 0; hstr16 <= 0;
    end else begin
      if (!bus8.mem_we_) begin
        we_low <= we_low + 1;
        if (bus8.mem_wdata != exp_wdata) wd_bad <= wd_bad + 1;
      end
      if (!bus8.mem_re_) re_low <= re_low + 1;
      if (!halted8_ && strobe8) hstr8 <= hstr8 + 1;
      if (!halted16_ && strobe16) hstr16 <= hstr16 + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic run_prog(input int max_cyc, output int cycles, output bit ok);
    @(posedge clk); #1 rst_ = 1'b0; clr_mon = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 rst_ = 1'b1; clr_mon = 1'b0;
    cycles = 0;
    ok = 1'b0;
    while (cycles < max_cyc && !ok) begin
      @(posedge clk); #1;
      cycles++;
      if (!halted8_) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic [7:0] r0, r1, fl, inst, ldv;
    logic [7:0] er0, er1, efl, epc;
  } vec_t;

  // Reference: one instruction at address 8 preceded by setup, followed by hlt at 9.
  function automatic vec_t model(input vec_t v);
    vec_t m;
    int s;
    logic [3:0] lo;
    m = v;
    lo = v.inst[3:0];
    m.er0 = v.r0; m.er1 = v.r1; m.efl = v.fl; m.epc = 8'd10;
    if (v.inst == 8'h00) begin
    end else if (v.inst[7:4] == 4'h1) begin
      if (lo == 4'd0)       m.er0 = v.r0;
      else if (lo == 4'd1)  m.er0 = v.r1;
      else if (lo == 4'd14) m.er0 = v.fl;
      else if (lo == 4'd15) m.er0 = 8'd9;
      else                  m.er0 = 8'd0;
    end else if (v.inst[7:4] == 4'h2) begin
      if (lo == 4'd1)                    m.er1 = v.r0;
      else if (lo == 4'd14)              m.efl = v.r0;
      else if (lo == 4'd15 && v.fl[0])   m.epc = v.r0 + 8'd1;
    end else if (v.inst == 8'h30) m.er0 = v.ldv;
    else if (v.inst == 8'h31) begin end
    else if (v.inst == 8'h32) m.er0 = 8'd0;
    else if (v.inst == 8'h33) m.efl[0] = ~v.fl[0];
    else if (v.inst == 8'h34) begin
      s = int'(v.r0) + int'(v.r1);
      m.er0 = 8'(s % 256);
      m.efl[1] = (s > 255);
    end else if (v.inst == 8'h35) begin
      m.er0 = v.r0 - v.r1;
      m.efl[1] = (v.r0 < v.r1);
    end else if (v.inst == 8'h3f) m.epc = 8'd9;
    else if (v.inst[7:6] == 2'b01) m.er0 = v.inst[4] ? {lo, v.r0[3:0]} : {4'h0, lo};
    else if (v.inst[7:6] == 2'b10 && lo == 4'd0) begin
      case (v.inst[5:4])
        2'd0: m.efl[0] = (v.r0 == 8'd0);
        2'd1: m.efl[0] = (v.r0 != 8'd0);
        2'd2: m.efl[0] = v.r0[7];
        default: m.efl[0] = v.r0[0];
      endcase
    end else m.efl[2] = 1'b1;
    return m;
  endfunction

  task automatic apply_vec(input vec_t v, input int wn, input string tag);
    int cyc;
    bit ok;
    for (int a = 0; a < 256; a++) mem8[a] = 8'h3f;
    mem8[0] = 8'h40 | {4'h0, v.r1[3:0]};
    mem8[1] = 8'h50 | {4'h0, v.r1[7:4]};
    mem8[2] = 8'h21;
    mem8[3] = 8'h40 | {4'h0, v.fl[3:0]};
    mem8[4] = 8'h50 | {4'h0, v.fl[7:4]};
    mem8[5] = 8'h2e;
    mem8[6] = 8'h40 | {4'h0, v.r0[3:0]};
    mem8[7] = 8'h50 | {4'h0, v.r0[7:4]};
    mem8[8] = v.inst;
    mem8[9] = 8'h3f;
    if (v.inst == 8'h30) mem8[v.r1] = v.ldv;
    wait_n = wn;
    exp_wdata = v.r0;
    run_prog(300, cyc, ok);
    chk($sformatf("%s halt", tag), 32'(ok), 32'd1);
    chk($sformatf("%s r0", tag), 32'(dut8.gpr_q[0]), 32'(v.er0));
    chk($sformatf("%s r1", tag), 32'(dut8.gpr_q[1]), 32'(v.er1));
    chk($sformatf("%s fl", tag), 32'(dut8.fl_q), 32'(v.efl));
    chk($sformatf("%s pc", tag), 32'(pc8), 32'(v.epc));
    if (v.inst == 8'h31)
      chk($sformatf("%s store", tag), {8'(st_count), 8'h00, st_addr, st_data}, {8'd1, 8'h00, v.r1, v.r0});
    else
      chk($sformatf("%s nostore", tag), 32'(st_count), 32'd0);
  endtask

  vec_t tbl [17];

  initial begin
    int cyc;
    bit ok;
    vec_t rv;

    for (int a = 0; a < 256; a++) begin
      mem8[a]  = 8'h3f;
      mem16[a] = 8'h3f;
    end
    // 16-bit core: r0=2, r1=r0, r0=1, sub, hlt -- from RESET_PC 0x10
    mem16[8'h10] = 8'h42; mem16[8'h11] = 8'h21; mem16[8'h12] = 8'h41;
    mem16[8'h13] = 8'h35; mem16[8'h14] = 8'h3f;

    tbl[0]  = '{8'hA5, 8'hA5, 8'h00, 8'h34, 8'h00, 8'h4A, 8'hA5, 8'h02, 8'h0A};
    tbl[1]  = '{8'h01, 8'h02, 8'h00, 8'h35, 8'h00, 8'hFF, 8'h02, 8'h02, 8'h0A};
    tbl[2]  = '{8'h05, 8'h03, 8'h02, 8'h35, 8'h00, 8'h02, 8'h03, 8'h00, 8'h0A};
    tbl[3]  = '{8'h00, 8'h00, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h01, 8'h0A};
    tbl[4]  = '{8'h20, 8'h00, 8'h01, 8'h2F, 8'h00, 8'h20, 8'h00, 8'h01, 8'h21};
    tbl[5]  = '{8'h20, 8'h00, 8'h00, 8'h2F, 8'h00, 8'h20, 8'h00, 8'h00, 8'h0A};
    tbl[6]  = '{8'h12, 8'h34, 8'h01, 8'hC7, 8'h00, 8'h12, 8'h34, 8'h05, 8'h0A};
    tbl[7]  = '{8'hFF, 8'h00, 8'h01, 8'h2F, 8'h00, 8'hFF, 8'h00, 8'h01, 8'h00};
    tbl[8]  = '{8'hF8, 8'h00, 8'h04, 8'h2E, 8'h00, 8'hF8, 8'h00, 8'hF8, 8'h0A};
    tbl[9]  = '{8'h3C, 8'h00, 8'h00, 8'h5A, 8'h00, 8'hAC, 8'h00, 8'h00, 8'h0A};
    tbl[10] = '{8'h03, 8'h00, 8'h00, 8'hB0, 8'h00, 8'h03, 8'h00, 8'h01, 8'h0A};
    tbl[11] = '{8'h00, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h09, 8'h00, 8'h00, 8'h0A};
    tbl[12] = '{8'h00, 8'h90, 8'h00, 8'h30, 8'h77, 8'h77, 8'h90, 8'h00, 8'h0A};
    tbl[13] = '{8'h11, 8'h22, 8'h00, 8'h3F, 8'h00, 8'h11, 8'h22, 8'h00, 8'h09};
    tbl[14] = '{8'h00, 8'h00, 8'h01, 8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 8'h0A};
    tbl[15] = '{8'h00, 8'h00, 8'h06, 8'h1E, 8'h00, 8'h06, 8'h00, 8'h06, 8'h0A};
    tbl[16] = '{8'h00, 8'h00, 8'h00, 8'h36, 8'h00, 8'h00, 8'h00, 8'h04, 8'h0A};

    // Reset in the middle of a fetch whose ack is withheld
    withhold = 1'b1;
    @(posedge clk); #1 rst_ = 1'b0;
    @(posedge clk); #1 rst_ = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("stuck fetch re_", 32'(bus8.mem_re_), 32'd0);
    chk("stuck fetch addr", 32'(bus8.mem_addr), 32'h00);
    rst_ = 1'b0;
    @(posedge clk); #1;
    chk("reset re_", 32'(bus8.mem_re_), 32'd1);
    chk("reset we_", 32'(bus8.mem_we_), 32'd1);
    chk("reset halted_", 32'(halted8_), 32'd1);
    chk("reset addr/wdata", {24'h0, bus8.mem_addr} | {24'h0, bus8.mem_wdata}, 32'h0);
    chk("reset pc", 32'(pc8), 32'h00);
    withhold = 1'b0;
    rst_ = 1'b1;
    @(posedge clk); #1;
    chk("boot then fetch re_", 32'(bus8.mem_re_), 32'd0);
    chk("boot then fetch addr", 32'(bus8.mem_addr), 32'h00);

    // im 5, im-high A, cpt 1, add, hlt: two cycles per op, zero wait
    for (int a = 0; a < 256; a++) mem8[a] = 8'h3f;
    mem8[0] = 8'h45; mem8[1] = 8'h5A; mem8[2] = 8'h21; mem8[3] = 8'h34; mem8[4] = 8'h3f;
    wait_n = 0;
    run_prog(200, cyc, ok);
    chk("alu seq cycles", 32'(cyc), 32'd11);
    chk("alu seq r1", 32'(dut8.gpr_q[1]), 32'hA5);
    chk("alu seq r0", 32'(dut8.gpr_q[0]), 32'h4A);
    chk("alu seq fl", 32'(dut8.fl_q), 32'h02);
    chk("alu seq fetches", 32'(re_low), 32'd5);

    // st 0x3C to 0x80 with three wait states on every access
    for (int a = 0; a < 256; a++) mem8[a] = 8'h3f;
    mem8[0] = 8'h40; mem8[1] = 8'h58; mem8[2] = 8'h21;
    mem8[3] = 8'h4C; mem8[4] = 8'h53; mem8[5] = 8'h31; mem8[6] = 8'h3f;
    wait_n = 3;
    exp_wdata = 8'h3C;
    run_prog(300, cyc, ok);
    chk("st seq cycles", 32'(cyc), 32'd40);
    chk("st we_ low cycles", 32'(we_low), 32'd4);
    chk("st wdata stable", 32'(wd_bad), 32'd0);
    chk("st count", 32'(st_count), 32'd1);
    chk("st addr/data", {16'h0, st_addr, st_data}, 32'h803C);
    repeat (10) @(posedge clk);
    #1;
    chk("no strobes after hlt", 32'(hstr8), 32'd0);

    foreach (tbl[i]) apply_vec(tbl[i], 0, $sformatf("tbl%0d", i));

    for (int n = 0; n < 40; n++) begin
      rv.r0 = 8'($urandom);
      rv.r1 = 8'($urandom);
      rv.fl = 8'($urandom);
      rv.ldv = 8'($urandom);
      if ($urandom_range(0, 1) == 0) rv.inst = 8'($urandom);
      else rv.inst = 8'h30 + 8'($urandom_range(0, 5));
      if (rv.inst == 8'h2F) rv.r0 = rv.r0 | 8'h10;
      if (rv.inst == 8'h30 || rv.inst == 8'h31) rv.r1 = rv.r1 | 8'h10;
      rv = model(rv);
      apply_vec(rv, $urandom_range(0, 2), $sformatf("rnd%0d i=%0h", n, rv.inst));
    end

    // 16-bit core ran alongside from the last reset
    repeat (20) @(posedge clk);
    #1;
    chk("w16 sub r0", 32'(dut16.gpr_q[0]), 32'h0000FFFF);
    chk("w16 sub fl", 32'(dut16.fl_q), 32'h0002);
    chk("w16 halted_", 32'(halted16_), 32'd0);
    chk("w16 pc", 32'(pc16), 32'h15);
    chk("w16 no strobes after hlt", 32'(hstr16), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
